// File: rtl/reg_file_stk.sv
// Register file with MOV/INC/DEC/LOAD/FLIP ops and a CALL/RET return-address stack.
// Optional build macro RF_STACK_WRAP_EN: CALL on a full stack overwrites the oldest entry instead of faulting.
module reg_file_stk #(
  parameter int DATA_W    = 8,
  parameter int NREGS     = 16,
  parameter int ADDR_W    = 10,
  parameter int STK_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [$clog2(NREGS)-1:0] src,
  input  logic [$clog2(NREGS)-1:0] dst,
  input  logic [3:0]               imm,
  input  logic [DATA_W-1:0]        load_data,
  input  logic [ADDR_W-1:0]        pc,
  input  logic [$clog2(NREGS)-1:0] rd_sel,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     src_zero,
  output logic [ADDR_W-1:0]        ret_addr,
  output logic                     ret_valid,
  output logic                     stk_full,
  output logic                     stk_empty,
  output logic                     err
);
  localparam int SEL_W  = $clog2(NREGS);
  localparam int CNT_W  = $clog2(STK_DEPTH + 1);
  localparam int PTR_W  = $clog2(STK_DEPTH);
  localparam int BIT_RAW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BIT_W  = (BIT_RAW > 4) ? 4 : BIT_RAW;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;
  localparam logic [2:0] OP_FLIP = 3'b111;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [ADDR_W-1:0] stk_q  [STK_DEPTH];
  logic [ADDR_W-1:0] stk_d  [STK_DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
  logic              ret_valid_q, ret_valid_d;
  logic              stk_full_q, stk_full_d;
  logic              stk_empty_q, stk_empty_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] src_val, dst_val, rd_val, step, wr_val;
  logic              wr_en, dst_ok;
  logic [PTR_W-1:0]  push_idx, top_idx;
  logic              unused_imm;

  assign unused_imm = ^imm;

  // Index 0 and out-of-range indices both read as zero.
  always_comb begin
    src_val = '0;
    dst_val = '0;
    rd_val  = '0;
    if (src != '0 && 32'(src) < NREGS)       src_val = regs_q[src];
    if (dst != '0 && 32'(dst) < NREGS)       dst_val = regs_q[dst];
    if (rd_sel != '0 && 32'(rd_sel) < NREGS) rd_val  = regs_q[rd_sel];
  end

  assign dst_ok   = (dst != '0) && (32'(dst) < NREGS);
  assign step     = DATA_W'(imm[2:0]) + DATA_W'(1);
  assign push_idx = PTR_W'(cnt_q);
  assign top_idx  = PTR_W'(cnt_q - CNT_W'(1));

  always_comb begin
    regs_d      = regs_q;
    stk_d       = stk_q;
    cnt_d       = cnt_q;
    ret_addr_d  = ret_addr_q;
    ret_valid_d = 1'b0;
    err_d       = err_q;
    wr_en       = 1'b0;
    wr_val      = '0;

    case (op)
      OP_MOV: begin
        wr_en  = 1'b1;
        wr_val = (src == dst) ? '0 : src_val;
      end
      OP_INC: begin
        wr_en  = 1'b1;
        wr_val = src_val + step;
      end
      OP_DEC: begin
        wr_en  = 1'b1;
        wr_val = src_val - step;
      end
      OP_LOAD: begin
        wr_en  = 1'b1;
        wr_val = load_data;
      end
      OP_FLIP: begin
        wr_en  = 1'b1;
        wr_val = dst_val ^ (DATA_W'(1) << imm[BIT_W-1:0]);
      end
      OP_CALL: begin
        if (cnt_q != CNT_W'(STK_DEPTH)) begin
          stk_d[push_idx] = pc + ADDR_W'(1);
          cnt_d           = cnt_q + CNT_W'(1);
        end else begin
`ifdef RF_STACK_WRAP_EN
          // Full stack: slide everything down one slot, dropping the oldest.
          for (int i = 0; i < STK_DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
          stk_d[STK_DEPTH-1] = pc + ADDR_W'(1);
`else
          err_d = 1'b1;
`endif
        end
      end
      OP_RET: begin
        if (cnt_q != '0) begin
          ret_addr_d  = stk_q[top_idx];
          ret_valid_d = 1'b1;
          cnt_d       = cnt_q - CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      OP_NOP:  ;
      default: ;
    endcase

    if (wr_en && dst_ok) regs_d[dst] = wr_val;
    regs_d[0] = '0;

    stk_full_d  = (cnt_d == CNT_W'(STK_DEPTH));
    stk_empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (start) begin
      for (int i = 0; i < NREGS; i++)     regs_q[i] <= '0;
      for (int i = 0; i < STK_DEPTH; i++) stk_q[i]  <= '0;
      cnt_q       <= '0;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
      stk_full_q  <= 1'b0;
      stk_empty_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      stk_q       <= stk_d;
      cnt_q       <= cnt_d;
      ret_addr_q  <= ret_addr_d;
      ret_valid_q <= ret_valid_d;
      stk_full_q  <= stk_full_d;
      stk_empty_q <= stk_empty_d;
      err_q       <= err_d;
    end
  end

  assign rd_data   = rd_val;
  assign src_zero  = (src_val == '0);
  assign ret_addr  = ret_addr_q;
  assign ret_valid = ret_valid_q;
  assign stk_full  = stk_full_q;
  assign stk_empty = stk_empty_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_file_stk.sv
// Directed bench for reg_file_stk: register ops, zero register, FLIP, return stack and reset override.
module tb_reg_file_stk;
  localparam logic [2:0] NOP = 3'b000, MOV = 3'b001, INC = 3'b010, DEC = 3'b011;
  localparam logic [2:0] LOAD = 3'b100, CALL = 3'b101, RET = 3'b110, FLIP = 3'b111;

  logic       clk = 1'b0;
  logic       start;
  logic [2:0] op;
  logic [3:0] src, dst, rd_sel, imm;
  logic [7:0] load_data, rd_data;
  logic [9:0] pc, ret_addr;
  logic       src_zero, ret_valid, stk_full, stk_empty, err;

  int total = 0;
  int bad   = 0;

  reg_file_stk dut (
    .clk(clk), .start(start), .op(op), .src(src), .dst(dst), .imm(imm),
    .load_data(load_data), .pc(pc), .rd_sel(rd_sel), .rd_data(rd_data),
    .src_zero(src_zero), .ret_addr(ret_addr), .ret_valid(ret_valid),
    .stk_full(stk_full), .stk_empty(stk_empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one op across a rising edge, then return to NOP just after it.
  task automatic do_op(input logic [2:0] o, input int s, input int d, input int i,
                       input logic [7:0] ld, input logic [9:0] p);
    op = o; src = 4'(s); dst = 4'(d); imm = 4'(i); load_data = ld; pc = p;
    @(posedge clk);
    #1;
    op = NOP;
  endtask

  task automatic read_chk(input string tag, input int sel, input logic [7:0] exp);
    rd_sel = 4'(sel);
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic zero_chk(input string tag, input int s, input logic exp);
    src = 4'(s);
    #1;
    check(tag, 32'(src_zero), 32'(exp));
  endtask

  task automatic reset_dut();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    start = 1'b0; op = NOP; src = '0; dst = '0; imm = '0;
    load_data = '0; pc = '0; rd_sel = '0;
    reset_dut();

    read_chk("rst_r3", 3, 8'h00);
    check("rst_empty", 32'(stk_empty), 32'd1);
    check("rst_full", 32'(stk_full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rv", 32'(ret_valid), 32'd0);
    check("rst_ra", 32'(ret_addr), 32'h000);

    do_op(LOAD, 0, 3, 0, 8'h5A, '0);
    do_op(MOV, 3, 4, 0, '0, '0);
    read_chk("mov_r4", 4, 8'h5A);
    do_op(INC, 4, 4, 2, '0, '0);
    read_chk("load_r3", 3, 8'h5A);
    read_chk("inc_r4", 4, 8'h5D);
    do_op(MOV, 4, 4, 0, '0, '0);
    read_chk("clr_r4", 4, 8'h00);
    zero_chk("zero_r4", 4, 1'b1);
    zero_chk("zero_r3", 3, 1'b0);

    do_op(LOAD, 0, 5, 0, 8'hFF, '0);
    do_op(INC, 5, 5, 0, '0, '0);
    read_chk("inc_wrap", 5, 8'h00);
    zero_chk("zero_r5", 5, 1'b1);
    do_op(DEC, 5, 5, 7, '0, '0);
    read_chk("dec_wrap", 5, 8'hF8);
    zero_chk("nz_r5", 5, 1'b0);
    do_op(DEC, 3, 7, 15, '0, '0);
    read_chk("dec_imm3", 7, 8'h52);

    do_op(LOAD, 0, 0, 0, 8'h11, '0);
    read_chk("r0_zero", 0, 8'h00);
    do_op(FLIP, 3, 6, 7, '0, '0);
    read_chk("flip1", 6, 8'h80);
    do_op(FLIP, 3, 6, 7, '0, '0);
    read_chk("flip2", 6, 8'h00);
    do_op(FLIP, 0, 6, 2, '0, '0);
    read_chk("flip_b2", 6, 8'h04);

    do_op(CALL, 0, 0, 0, '0, 10'h3FF);
    check("call_nempty", 32'(stk_empty), 32'd0);
    do_op(CALL, 0, 0, 0, '0, 10'h010);
    do_op(CALL, 0, 0, 0, '0, 10'h020);
    check("call3_nfull", 32'(stk_full), 32'd0);
    check("call_rv", 32'(ret_valid), 32'd0);
    do_op(RET, 0, 0, 0, '0, '0);
    check("ret1_addr", 32'(ret_addr), 32'h021);
    check("ret1_v", 32'(ret_valid), 32'd1);
    do_op(RET, 0, 0, 0, '0, '0);
    check("ret2_addr", 32'(ret_addr), 32'h011);
    check("ret2_v", 32'(ret_valid), 32'd1);
    do_op(RET, 0, 0, 0, '0, '0);
    check("ret3_addr", 32'(ret_addr), 32'h000);
    check("ret3_v", 32'(ret_valid), 32'd1);
    check("ret3_empty", 32'(stk_empty), 32'd1);
    do_op(NOP, 0, 0, 0, '0, '0);
    check("rv_pulse", 32'(ret_valid), 32'd0);
    check("err_pre", 32'(err), 32'd0);
    do_op(RET, 0, 0, 0, '0, '0);
    check("ret4_v", 32'(ret_valid), 32'd0);
    check("ret4_err", 32'(err), 32'd1);
    do_op(NOP, 0, 0, 0, '0, '0);
    check("err_sticky", 32'(err), 32'd1);

    reset_dut();
    check("rst2_err", 32'(err), 32'd0);
    for (int k = 1; k <= 4; k++) do_op(CALL, 0, 0, 0, '0, 10'(k));
    check("four_full", 32'(stk_full), 32'd1);
    check("four_err", 32'(err), 32'd0);
    do_op(CALL, 0, 0, 0, '0, 10'd5);
    check("five_full", 32'(stk_full), 32'd1);
`ifdef RF_STACK_WRAP_EN
    check("five_err", 32'(err), 32'd0);
    for (int k = 0; k < 4; k++) begin
      do_op(RET, 0, 0, 0, '0, '0);
      check("wrap_pop", 32'(ret_addr), 32'(6 - k));
    end
`else
    check("five_err", 32'(err), 32'd1);
    for (int k = 0; k < 4; k++) begin
      do_op(RET, 0, 0, 0, '0, '0);
      check("drop_pop", 32'(ret_addr), 32'(5 - k));
    end
`endif
    check("pops_empty", 32'(stk_empty), 32'd1);
    check("pops_nfull", 32'(stk_full), 32'd0);

    reset_dut();
    start = 1'b1;
    do_op(CALL, 0, 0, 0, '0, 10'h055);
    start = 1'b0;
    check("start_call_empty", 32'(stk_empty), 32'd1);
    check("start_call_err", 32'(err), 32'd0);
    do_op(RET, 0, 0, 0, '0, '0);
    check("start_call_ret_v", 32'(ret_valid), 32'd0);
    check("start_call_ret_err", 32'(err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
